// File: rtl/ahb_arb_pkg.sv
// Shared types, defaults and helpers for the round-robin AHB bus arbiter.
package ahb_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_SEL_W       = 2;
    localparam int DEF_LEN_W       = 5;
    localparam int MAX_MASTERS     = 8;

    function automatic logic [MAX_MASTERS-1:0] onehot(input logic [2:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin winner search starting one past the last granted index.
module ahb_rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int MI_W        = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MI_W-1:0]        ptr,
    output logic                   valid,
    output logic [MI_W-1:0]        winner
);

    // Walk from the farthest candidate back to ptr+1 so the nearest requester is written last.
    always_comb begin
        logic [MI_W:0] cand;
        valid  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = {1'b0, ptr} + (MI_W+1)'(k);
            if (cand >= (MI_W+1)'(NUM_MASTERS))
                cand = cand - (MI_W+1)'(NUM_MASTERS);
            if (req[cand[MI_W-1:0]]) begin
                valid  = 1'b1;
                winner = cand[MI_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Burst-aware round-robin arbiter: holds a grant for a counted burst, with locked re-grant.
module ahb_rr_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int SEL_W       = DEF_SEL_W,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int MI_W        = $clog2(NUM_MASTERS)
) (
    input  logic                         hclk,
    input  logic                         hreset,
    input  logic [NUM_MASTERS-1:0]       hreq,
    input  logic [NUM_MASTERS-1:0]       hlock,
    input  logic [NUM_MASTERS*SEL_W-1:0] sel_in,
    input  logic [NUM_MASTERS*LEN_W-1:0] hlen,
    input  logic                         hready,
    output logic [NUM_MASTERS-1:0]       hgrant,
    output logic [MI_W-1:0]              hmaster,
    output logic [SEL_W-1:0]             sel,
    output logic                         busy,
    output logic [LEN_W-1:0]             beats_left
);

    arb_state_e             state_q, state_d;
    logic [MI_W-1:0]        ptr_q, ptr_d;
    logic [NUM_MASTERS-1:0] hgrant_d;
    logic [MI_W-1:0]        hmaster_d;
    logic [SEL_W-1:0]       sel_d;
    logic                   busy_d;
    logic [LEN_W-1:0]       beats_d;

    logic                   pick_valid;
    logic [MI_W-1:0]        pick_win;
    logic                   do_load;
    logic [MI_W-1:0]        load_idx;
    logic [MAX_MASTERS-1:0] oh_full;
    logic [LEN_W-1:0]       len_w;

    logic [SEL_W-1:0] sel_arr [NUM_MASTERS];
    logic [LEN_W-1:0] len_arr [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign sel_arr[i] = sel_in[i*SEL_W +: SEL_W];
        assign len_arr[i] = hlen[i*LEN_W +: LEN_W];
    end

    ahb_rr_pick #(
        .NUM_MASTERS(NUM_MASTERS),
        .MI_W       (MI_W)
    ) u_pick (
        .req   (hreq),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .winner(pick_win)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hgrant_d  = hgrant;
        hmaster_d = hmaster;
        sel_d     = sel;
        busy_d    = busy;
        beats_d   = beats_left;
        do_load   = 1'b0;
        load_idx  = pick_win;
        oh_full   = '0;
        len_w     = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    do_load = 1'b1;
                    ptr_d   = pick_win;
                end
            end
            BURST: begin
                if (hready) begin
                    if (beats_left == LEN_W'(1)) begin
                        // A locked master still requesting keeps the bus; ptr stays put.
                        if (hlock[hmaster] && hreq[hmaster]) begin
                            do_load  = 1'b1;
                            load_idx = hmaster;
                        end else if (pick_valid) begin
                            do_load = 1'b1;
                            ptr_d   = pick_win;
                        end else begin
                            state_d  = IDLE;
                            hgrant_d = '0;
                            sel_d    = '0;
                            busy_d   = 1'b0;
                            beats_d  = '0;
                        end
                    end else begin
                        beats_d = beats_left - LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_load) begin
            oh_full   = onehot(3'(load_idx));
            len_w     = len_arr[load_idx];
            state_d   = BURST;
            hgrant_d  = oh_full[NUM_MASTERS-1:0];
            hmaster_d = load_idx;
            sel_d     = sel_arr[load_idx];
            busy_d    = 1'b1;
            beats_d   = (len_w == '0) ? LEN_W'(1) : len_w;
        end
    end

    // Reset points ptr at the last master so the first search starts at master 0.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= IDLE;
            ptr_q      <= MI_W'(NUM_MASTERS-1);
            hgrant     <= '0;
            hmaster    <= '0;
            sel        <= '0;
            busy       <= 1'b0;
            beats_left <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hgrant     <= hgrant_d;
            hmaster    <= hmaster_d;
            sel        <= sel_d;
            busy       <= busy_d;
            beats_left <= beats_d;
        end
    end

endmodule
